// File: rtl/fpga_txn_sequencer.sv
// Board front end for one master_interface port. The start button is
// synchronised and debounced. Each clean press captures the switches and
// issues one transaction, which is then tracked to completion or timeout.
module fpga_txn_sequencer #(
  parameter int ADDR_WIDTH           = 16,
  parameter int DATA_WIDTH           = 8,
  parameter int SLAVE_MEM_ADDR_WIDTH = 12,
  parameter int DEBOUNCE_CYCLES      = 16,
  parameter int TIMEOUT_CYCLES       = 1024
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start_btn,
  input  logic                  mode_sw,
  input  logic [1:0]            device_sw,
  input  logic [5:0]            mem_addr_sw,
  input  logic [DATA_WIDTH-1:0] wdata_sw,
  output logic [ADDR_WIDTH-1:0] maddr,
  output logic [DATA_WIDTH-1:0] mwdata,
  output logic                  wen,
  output logic                  mwvalid,
  input  logic                  mready,
  input  logic [DATA_WIDTH-1:0] mrdata,
  input  logic                  mrvalid,
  output logic [DATA_WIDTH-1:0] rdata_out,
  output logic                  busy,
  output logic                  done_pulse,
  output logic                  timeout_err,
  output logic [7:0]            txn_count
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMW = $clog2(TIMEOUT_CYCLES);
  localparam logic [DBW-1:0] DEB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DBW-1:0] DEB_MAX  = DBW'(DEBOUNCE_CYCLES);
  localparam logic [TMW-1:0] TMO_LAST = TMW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACC,
    S_WAIT_RESP,
    S_DONE
  } state_t;

  state_t                state_q;
  logic                  btn_s1_q, btn_s2_q;
  logic [DBW-1:0]        deb_q, deb_d;
  logic                  press_acc;
  logic [TMW-1:0]        tmo_q;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [ADDR_WIDTH-1:0] maddr_q;
  logic [DATA_WIDTH-1:0] mwdata_q;
  logic                  wen_q;
  logic                  mwvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  timeout_q;
  logic [7:0]            count_q;

  // Two-flop synchroniser for the asynchronous button
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      btn_s1_q <= 1'b0;
      btn_s2_q <= 1'b0;
    end else begin
      btn_s1_q <= start_btn;
      btn_s2_q <= btn_s1_q;
    end
  end

  // Debounce counter: counts while held, saturates so a press fires once per high period
  always_comb begin
    deb_d = '0;
    if (btn_s2_q) begin
      if (deb_q != DEB_MAX) deb_d = deb_q + 1'b1;
      else                  deb_d = deb_q;
    end
  end

  assign press_acc = btn_s2_q && (deb_q == DEB_LAST);

  // Debounce counter register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) deb_q <= '0;
    else       deb_q <= deb_d;
  end

  // Bus address built from the switches: device select just above the slave memory field
  always_comb begin
    addr_d                             = '0;
    addr_d[SLAVE_MEM_ADDR_WIDTH +: 2]  = device_sw;
    addr_d[5:0]                        = mem_addr_sw;
  end

  // Transaction FSM with registered outputs; timeout takes priority over progress
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      tmo_q     <= '0;
      maddr_q   <= '0;
      mwdata_q  <= '0;
      wen_q     <= 1'b0;
      mwvalid_q <= 1'b0;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      count_q   <= '0;
    end else begin
      mwvalid_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (press_acc) begin
            maddr_q   <= addr_d;
            mwdata_q  <= wdata_sw;
            wen_q     <= mode_sw;
            timeout_q <= 1'b0;
            busy_q    <= 1'b1;
            tmo_q     <= '0;
            state_q   <= S_ISSUE;
          end
        end
        S_ISSUE, S_WAIT_ACC, S_WAIT_RESP: begin
          if (tmo_q == TMO_LAST) begin
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
            if (state_q == S_ISSUE) begin
              if (mready) begin
                mwvalid_q <= 1'b1;
                state_q   <= S_WAIT_ACC;
              end
            end else if (state_q == S_WAIT_ACC) begin
              if (!wen_q && mrvalid) begin
                rdata_q <= mrdata;
                done_q  <= 1'b1;
                count_q <= count_q + 8'd1;
                busy_q  <= 1'b0;
                state_q <= S_DONE;
              end else if (!mready) begin
                state_q <= S_WAIT_RESP;
              end
            end else begin
              if (wen_q ? mready : mrvalid) begin
                if (!wen_q) rdata_q <= mrdata;
                done_q  <= 1'b1;
                count_q <= count_q + 8'd1;
                busy_q  <= 1'b0;
                state_q <= S_DONE;
              end
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign maddr       = maddr_q;
  assign mwdata      = mwdata_q;
  assign wen         = wen_q;
  assign mwvalid     = mwvalid_q;
  assign rdata_out   = rdata_q;
  assign busy        = busy_q;
  assign done_pulse  = done_q;
  assign timeout_err = timeout_q;
  assign txn_count   = count_q;

endmodule
